// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and pointer-width helper for sync_mem and its controllers
package mem_pkg;

  // Default geometry: 2**DEPTH entries of WIDTH bits
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 4;

  // FIFO pointers carry one extra wrap bit above the memory address
  function automatic int ptr_width(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/sync_mem_fifo_ctrl.sv
// rtl/sync_mem_fifo_ctrl.sv - valid/ready FIFO controller driving a two-port synchronous memory
module sync_mem_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty,
  output logic             memWriteEnable0,
  output logic [WIDTH-1:0] memWriteData0,
  output logic [DEPTH-1:0] memAddress0,
  output logic             memWriteEnable1,
  output logic [WIDTH-1:0] memWriteData1,
  output logic [DEPTH-1:0] memAddress1,
  input  logic [WIDTH-1:0] memReadData1
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic          out_valid_q;
  logic          out_valid_next;
  logic          push;
  logic          pop;

  // Status derived purely from registered pointers, so inReady never depends on outReady
  always_comb begin
    count   = wr_ptr - rd_ptr;
    full    = (count == CAPACITY);
    empty   = (count == '0);
    inReady = !full;
  end

  // Handshake qualification; flush suppresses both sides for its cycle
  always_comb begin
    push = inValid && inReady && !flush;
    pop  = out_valid_q && outReady && !flush;
  end

  // Pointer advance and head-valid prediction; the head check uses the pre-push write
  // pointer because the memory returns the old word on a same-address write/read edge
  always_comb begin
    wr_ptr_next    = push ? (wr_ptr + PTR_ONE) : wr_ptr;
    rd_ptr_next    = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
    out_valid_next = ((wr_ptr - rd_ptr_next) != '0);
  end

  // Controller state: async reset and sync flush both return to the empty FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      out_valid_q <= out_valid_next;
    end
  end

  // Memory port drive: port 0 writes on push, port 1 prefetches the next head address
  always_comb begin
    memWriteEnable0 = push;
    memAddress0     = push ? wr_ptr[DEPTH-1:0] : '0;
    memWriteData0   = push ? inData : '0;
    memWriteEnable1 = 1'b0;
    memWriteData1   = '0;
    memAddress1     = rd_ptr_next[DEPTH-1:0];
  end

  // Consumer side: head data comes straight from the registered memory read
  always_comb begin
    outValid = out_valid_q;
    outData  = memReadData1;
  end

endmodule

// File: tb/tb_sync_mem_fifo_ctrl.sv
// tb/tb_sync_mem_fifo_ctrl.sv - randomized bench for sync_mem_fifo_ctrl against a queue model
module tb_sync_mem_fifo_ctrl;

  localparam int DEPTH = 2;
  localparam int WIDTH = 4;
  localparam int CAP   = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] inData = '0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [WIDTH-1:0] outData;
  logic [DEPTH:0]   count;
  logic             full;
  logic             empty;
  logic             memWriteEnable0;
  logic [WIDTH-1:0] memWriteData0;
  logic [DEPTH-1:0] memAddress0;
  logic             memWriteEnable1;
  logic [WIDTH-1:0] memWriteData1;
  logic [DEPTH-1:0] memAddress1;
  logic [WIDTH-1:0] memReadData1;

  sync_mem_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .count(count), .full(full), .empty(empty),
    .memWriteEnable0(memWriteEnable0), .memWriteData0(memWriteData0), .memAddress0(memAddress0),
    .memWriteEnable1(memWriteEnable1), .memWriteData1(memWriteData1), .memAddress1(memAddress1),
    .memReadData1(memReadData1)
  );

  always #5 clock = ~clock;

  // Two-port synchronous memory: registered read returns the old word on a same-edge write
  logic [WIDTH-1:0] mem [CAP];
  always @(posedge clock) begin
    if (memWriteEnable0) mem[memAddress0] <= memWriteData0;
    if (memWriteEnable1) mem[memAddress1] <= memWriteData1;
    memReadData1 <= mem[memAddress1];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stored entries in order, plus which of them the consumer can see
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] popped[$];
  int  wr_idx = 0;
  int  rd_idx = 0;
  bit  m_ov = 0;

  task automatic model_clear();
    q.delete();
    wr_idx = 0;
    rd_idx = 0;
    m_ov = 0;
  endtask

  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
    bit e_push, e_pop;
    int sz;
    inValid = iv; inData = id; outReady = ordy; flush = fl;
    #1;
    sz = q.size();
    e_push = iv && (sz < CAP) && !fl;
    e_pop  = m_ov && ordy && !fl;
    check("count", 32'(count), 32'(sz));
    check("full", 32'(full), 32'(sz == CAP));
    check("empty", 32'(empty), 32'(sz == 0));
    check("inReady", 32'(inReady), 32'(sz != CAP));
    check("outValid", 32'(outValid), 32'(m_ov));
    if (m_ov) check("outData", 32'(outData), 32'(q[0]));
    check("we0", 32'(memWriteEnable0), 32'(e_push));
    if (e_push) begin
      check("addr0", 32'(memAddress0), 32'(wr_idx % CAP));
      check("wdata0", 32'(memWriteData0), 32'(id));
    end
    check("addr1", 32'(memAddress1), 32'((rd_idx + int'(e_pop)) % CAP));
    check("we1", 32'(memWriteEnable1), 32'd0);
    check("wdata1", 32'(memWriteData1), 32'd0);
    if (outValid && outReady && !flush) popped.push_back(outData);
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else begin
      if (e_pop) begin
        void'(q.pop_front());
        rd_idx++;
      end
      m_ov = (q.size() != 0);
      if (e_push) begin
        q.push_back(id);
        wr_idx++;
      end
    end
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_outValid"}, 32'(outValid), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_inReady"}, 32'(inReady), 32'd1);
    check({tag, "_addr1"}, 32'(memAddress1), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 check_reset_state("rst");
    check("rst_we0", 32'(memWriteEnable0), 32'd0);
    check("rst_addr0", 32'(memAddress0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();

    // Single entry: visible two cycles after presentation, then empty
    step(1, 4'hA, 1, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 1, 0);
    #1;
    check("single_empty", 32'(empty), 32'd1);
    check("single_outValid", 32'(outValid), 32'd0);
    check("single_popped", 32'(popped.size() == 1 ? popped[0] : 4'hF), 32'hA);

    // Fill to capacity, try a fifth push, then drain
    popped.delete();
    for (int i = 1; i <= 5; i++) step(1, 4'(i), 0, 0);
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 6; i++) step(0, 4'h0, 1, 0);
    check("drain_n", 32'(popped.size()), 32'd4);
    for (int i = 0; i < popped.size() && i < 4; i++) check("drain_val", 32'(popped[i]), 32'(i + 1));

    // Continuous stream with wrap
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, 4'(i), 1, 0);
      check("stream_cnt_le2", 32'(count <= 2), 32'd1);
    end
    for (int i = 0; i < 4; i++) step(0, 4'h0, 1, 0);
    check("stream_n", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size() && i < 10; i++) check("stream_val", 32'(popped[i]), 32'(i));

    // Full with push and pop, then push and pop together
    for (int i = 0; i < 5; i++) step(1, 4'(i + 3), 0, 0);
    step(1, 4'hE, 1, 0);
    #1 check("fullpp_count", 32'(count), 32'd3);
    step(1, 4'hD, 1, 0);
    #1 check("pp_count", 32'(count), 32'd3);

    // Flush with push and pop offered: nothing written, everything cleared
    step(1, 4'hB, 1, 1);
    #1 check("flush_count", 32'(count), 32'd0);
    popped.delete();
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1, 0);
    check("flush_none", 32'(popped.size()), 32'd0);

    // Asynchronous reset mid-cycle with two entries held
    step(1, 4'h2, 0, 0);
    step(1, 4'h3, 0, 0);
    step(0, 4'h0, 0, 0);
    inValid = 1'b0; outReady = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state("midrst");
    #1 reset = 1'b0;
    model_clear();
    @(negedge clock);
    popped.delete();
    step(1, 4'h7, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 1, 0);
    check("midrst_n", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) check("midrst_val", 32'(popped[0]), 32'h7);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_mem_fifo_ctrl.md
# sync_mem_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of `sync_mem`, the two-port synchronous memory. It turns a valid/ready push stream into a valid/ready pop stream, using `sync_mem` as storage:
- Port 0 is write-only.
- Port 1 is read-only.

The controller owns the read/write pointers, the occupancy count and the full/empty status. It hides the memory's one-cycle registered read latency from the consumer.

## Interface
Parameters:
- `DEPTH`, 4, memory address width in bits; FIFO capacity is 2**DEPTH entries.
- `WIDTH`, 4, data width in bits.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all controller state.
- `flush`  in  1  synchronous clear of the FIFO; has priority over push and pop.
- `inValid`  in  1  producer offers `inData`.
- `inReady`  out  1  FIFO can accept a push.
- `inData`  in  WIDTH  push data.
- `outValid`  out  1  `outData` holds the head entry.
- `outReady`  in  1  consumer takes the head entry.
- `outData`  out  WIDTH  head data, wired directly from `memReadData1`.
- `count`  out  DEPTH+1  stored entries, range 0..2**DEPTH.
- `full`  out  1  `count == 2**DEPTH`.
- `empty`  out  1  `count == 0`.
- `memWriteEnable0`  out  1  drives `sync_mem` `writeEnable0`.
- `memWriteData0`  out  WIDTH  drives `writeData0`.
- `memAddress0`  out  DEPTH  drives `address0`.
- `memWriteEnable1`  out  1  drives `writeEnable1`; tied to 0.
- `memWriteData1`  out  WIDTH  drives `writeData1`; tied to 0.
- `memAddress1`  out  DEPTH  drives `address1`.
- `memReadData1`  in  WIDTH  from `readData1`.

## Operation
- Pointers: `wrPtr` and `rdPtr` are DEPTH+1 bits wide, with the MSB as the wrap bit. `count = wrPtr - rdPtr` (modulo 2**(DEPTH+1)).
- `inReady = !full`, taken from registered state, so it has no combinational dependence on `outReady`.
- Push = `inValid && inReady && !flush`.
  - On a push: `memWriteEnable0 = 1`, `memAddress0 = wrPtr[DEPTH-1:0]`, `memWriteData0 = inData`, and `wrPtr` increments.
  - All three memory write signals are combinational from the push condition.
- Pop = `outValid && outReady && !flush`. A pop increments `rdPtr`.
- Read prefetch: `memAddress1 = rdPtrNext[DEPTH-1:0]`, where `rdPtrNext = rdPtr + pop`.
  - This creates a combinational path from `outReady` to `memAddress1`; the path is accepted.
- `outValid` is a register. Its next value is `(wrPtr_q - rdPtrNext) != 0`, using `wrPtr_q` **before** this cycle's push.
  - Reason: `sync_mem` returns the old word when an address is written and read on the same edge.
  - Consequence: an entry becomes visible only one edge after it is written.
- Full with push and pop in the same cycle: no push, because `inReady` is already 0. The pop proceeds and `count` decrements.
- Empty with push: the entry is written; `outValid` stays 0 for the next cycle, so `empty=0` while `outValid=0` for one cycle.
- Flush: `wrPtr`, `rdPtr` and `outValid` clear on the edge. Push and pop are suppressed in that cycle, so no memory write occurs.
- Reset (asynchronous):
  - `wrPtr`, `rdPtr` and `outValid` go to 0 immediately.
  - Outputs then read `inReady=1`, `count=0`, `full=0`, `empty=1`, `memWriteEnable0=0` (unless `inValid`, which pushes).
  - `memAddress0=0` and `memAddress1=0`.
  - Memory contents are not cleared and are never relied on.

## Timing
- Push-to-pop latency: a push accepted at edge N gives `outValid=1` with that data after edge N+1 (two cycles from presenting `inData`).
- Throughput: one push and one pop per cycle, sustained. With continuous flow and `outReady=1`, `count` settles at 2.
- Pop: data is consumed at the edge where `outValid && outReady`. The next head appears after that same edge if it was written at least one edge earlier.
- Reset may assert or deassert between edges; state changes with no clock required. The first valid push is accepted on the first edge after deassertion.

## Structure
- Shared package `mem_pkg` holds:
  - Default `DEPTH`/`WIDTH` localparams.
  - A helper function for the pointer width (DEPTH+1).
- No sub-module is needed. The integration wrapper instantiates `sync_mem_fifo_ctrl` and `sync_mem` side by side.
- The memory's own reset input is driven by the wrapper, not by this block.

## Test plan
All scenarios use DEPTH=2 (4 entries) and WIDTH=4, with `sync_mem` attached.
- Reset, then push 0xA in cycle 0 with `outReady=1` -> `outValid=1`, `outData=0xA` in cycle 2; popped at that edge; `empty=1` and `outValid=0` in cycle 3.
- Push 0x1..0x4 with `outReady=0` -> `count=4`, `full=1`, `inReady=0`; a fifth push of 0x5 is ignored; the drain yields 0x1, 0x2, 0x3, 0x4, then `empty=1`.
- Stream 0x0..0x9 with `inValid=1` and `outReady=1` continuously -> output is 0x0..0x9 in order, one per cycle after the first appears; `count` never exceeds 2; pointers wrap past address 3.
- At `count=4`, assert `inValid` and pop -> no push, `count=3`; next cycle push and pop together -> `count` stays 3.
- At `count=3`, assert `flush` with `inValid=1` and `outReady=1` -> next cycle `count=0`, `outValid=0`, no `memWriteEnable0` pulse, pushed data never emerges.
- Assert `reset` mid-cycle at `count=2` -> `count`, `outValid` and `full` clear without a clock edge; after release, push 0x7 -> the only output is 0x7.
